// File: rtl/ens_layer_skid_reg_pkg.sv
// -----------------------------------------------------------------------------
// ens_layer_skid_reg_pkg
// Shared definitions for the layer-to-layer skid register of the LUT-neuron
// ensemble pipeline:
//   - skid_state_e        : occupancy state (EMPTY / ONE / FULL)
//   - ENS_DEFAULT_WIDTH   : default activation vector width
//   - ENS_DEFAULT_CNT_W   : default statistics counter width
//   - ens_sat_inc()       : saturating increment for counters up to SAT_W bits
// -----------------------------------------------------------------------------
package ens_layer_skid_reg_pkg;

  localparam int ENS_DEFAULT_WIDTH = 1024;
  localparam int ENS_DEFAULT_CNT_W = 32;

  // Widest counter the saturating helper supports; narrower counters are
  // zero-extended into this width by the caller.
  localparam int SAT_W = 64;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // nothing held
    ONE   = 2'd1,  // main register held
    FULL  = 2'd2   // main and skid registers held
  } skid_state_e;

  // Increment 'value' unless it already equals the all-ones pattern of a
  // 'width'-bit counter. A shift by SAT_W wraps to zero, so the subtraction
  // still yields all-ones for a full-width counter.
  function automatic logic [SAT_W-1:0] ens_sat_inc(
    input logic [SAT_W-1:0] value,
    input int unsigned      width
  );
    logic [SAT_W-1:0] max_v;
    if (width >= SAT_W) begin
      max_v = {SAT_W{1'b1}};
    end else begin
      max_v = (64'd1 << width) - 64'd1;
    end
    if (value == max_v) begin
      return value;
    end else begin
      return value + 64'd1;
    end
  endfunction

endpackage

// File: rtl/ens_layer_skid_reg_sat_counter.sv
// -----------------------------------------------------------------------------
// ens_sat_counter
// Saturating event counter: counts cycles with inc=1 and sticks at all-ones.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, clears the count
//   inc  - count enable for this cycle
//   cnt  - current count (registered)
// -----------------------------------------------------------------------------
module ens_sat_counter
  import ens_layer_skid_reg_pkg::*;
#(
  parameter int CNT_W = ENS_DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_r;
  logic [SAT_W-1:0] cnt_ext_s;
  logic [SAT_W-1:0] next_ext_s;
  logic             unused_ext_s;

  // Widen the count for the shared helper and compute its saturated successor
  always_comb begin
    cnt_ext_s              = {SAT_W{1'b0}};
    cnt_ext_s[CNT_W-1:0]   = cnt_r;
    next_ext_s             = ens_sat_inc(cnt_ext_s, CNT_W);
  end

  // Bits above CNT_W are always zero and intentionally dropped
  assign unused_ext_s = ^next_ext_s;

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc) begin
      cnt_r <= next_ext_s[CNT_W-1:0];
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/ens_layer_skid_reg.sv
// -----------------------------------------------------------------------------
// ens_layer_skid_reg
// Two-entry skid register between LUT-neuron layer N and layer N+1. Breaks the
// ready path: in_ready comes straight from a flop, so out_ready never reaches
// in_ready combinationally. Full throughput with one cycle of latency.
//
// Parameters:
//   WIDTH  - activation vector width (one bit per upstream neuron)
//   CNT_W  - statistics counter width
// Ports:
//   clk                 - rising-edge clock
//   rst                 - asynchronous active-high reset
//   flush               - synchronous discard of all held vectors
//   in_data/in_valid    - upstream vector and its valid
//   in_ready            - block accepts in_data this cycle (registered)
//   out_data/out_valid  - vector to layer N+1 and its valid (registered)
//   out_ready           - downstream accepts out_data
//   xfer_cnt/stall_cnt  - output transfers / stalled cycles with data held
//
// Build option: define ENS_LAYER_SKID_STATS_EN to instantiate the saturating
// statistics counters; otherwise both counter outputs are constant zero.
// -----------------------------------------------------------------------------
module ens_layer_skid_reg
  import ens_layer_skid_reg_pkg::*;
#(
  parameter int WIDTH = ENS_DEFAULT_WIDTH,
  parameter int CNT_W = ENS_DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  skid_state_e      state_r;
  skid_state_e      state_next_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] skid_r;
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic             main_load_s;
  logic             main_from_skid_s;
  logic             skid_load_s;

  assign in_xfer_s  = in_valid & in_ready_r;
  assign out_xfer_s = out_valid_r & out_ready;

  // Next occupancy state and which data register loads this cycle
  always_comb begin
    state_next_s     = state_r;
    main_load_s      = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    if (flush) begin
      // Drop everything, including a same-cycle input transfer
      state_next_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_xfer_s) begin
            state_next_s = ONE;
            main_load_s  = 1'b1;
          end else begin
            state_next_s = EMPTY;
          end
        end
        ONE: begin
          if (in_xfer_s && out_xfer_s) begin
            state_next_s = ONE;
            main_load_s  = 1'b1;
          end else if (in_xfer_s) begin
            state_next_s = FULL;
            skid_load_s  = 1'b1;
          end else if (out_xfer_s) begin
            state_next_s = EMPTY;
          end else begin
            state_next_s = ONE;
          end
        end
        FULL: begin
          // in_ready is low in FULL, so only the output side can move
          if (out_xfer_s) begin
            state_next_s     = ONE;
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
          end else begin
            state_next_s = FULL;
          end
        end
        default: begin
          state_next_s = EMPTY;
        end
      endcase
    end
  end

  // State plus handshake flops; both handshakes are decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= EMPTY;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s != FULL);
      out_valid_r <= (state_next_s != EMPTY);
    end
  end

  // Main register: loads from the input or from the skid entry on a transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_r <= {WIDTH{1'b0}};
    end else if (main_load_s) begin
      main_r <= main_from_skid_s ? skid_r : in_data;
    end
  end

  // Skid register: catches the vector accepted while the output stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_r <= {WIDTH{1'b0}};
    end else if (skid_load_s) begin
      skid_r <= in_data;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;

`ifdef ENS_LAYER_SKID_STATS_EN
  // Statistics survive flush; only rst clears them
  ens_sat_counter #(.CNT_W(CNT_W)) u_xfer_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_xfer_s),
    .cnt (xfer_cnt)
  );

  ens_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_valid_r & ~out_ready),
    .cnt (stall_cnt)
  );
`else
  assign xfer_cnt  = {CNT_W{1'b0}};
  assign stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ens_layer_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_ens_layer_skid_reg
// Self-checking bench for ens_layer_skid_reg. A queue holds the vectors the
// block should be holding; out_valid/out_data/in_ready and the statistics are
// derived from that queue's size and head every cycle.
// -----------------------------------------------------------------------------
module tb_ens_layer_skid_reg;

  localparam int W  = 1024;
  localparam int CW = 32;
`ifdef ENS_LAYER_SKID_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] xfer_cnt;
  logic [CW-1:0] stall_cnt;

  int            num_checks = 0;
  int            num_errors = 0;

  // Reference model state
  logic [W-1:0]  model_q[$];
  int unsigned   exp_xfer;
  int unsigned   exp_stall;
  bit            ready_en;

  always #5 clk = ~clk;

  ens_layer_skid_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt),
    .stall_cnt (stall_cnt)
  );

  task automatic check_value(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got %h expected %h (low 120 bits)", tag, got[119:0], exp[119:0]);
    end
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic check_outputs(input string tag);
    logic [CW-1:0] ex;
    logic [CW-1:0] es;
    ex = STATS_ON ? CW'(exp_xfer)  : {CW{1'b0}};
    es = STATS_ON ? CW'(exp_stall) : {CW{1'b0}};
    check_value({tag, ".out_valid"}, W'(out_valid), W'(model_q.size() > 0));
    check_value({tag, ".in_ready"},  W'(in_ready),  W'(ready_en && (model_q.size() < 2)));
    if (model_q.size() > 0) check_value({tag, ".out_data"}, out_data, model_q[0]);
    check_value({tag, ".xfer_cnt"},  W'(xfer_cnt),  W'(ex));
    check_value({tag, ".stall_cnt"}, W'(stall_cnt), W'(es));
  endtask

  task automatic check_reset_state(input string tag);
    check_value({tag, ".out_valid"}, W'(out_valid), W'(1'b0));
    check_value({tag, ".in_ready"},  W'(in_ready),  W'(1'b0));
    check_value({tag, ".out_data"},  out_data,      {W{1'b0}});
    check_value({tag, ".xfer_cnt"},  W'(xfer_cnt),  W'(1'b0));
    check_value({tag, ".stall_cnt"}, W'(stall_cnt), W'(1'b0));
  endtask

  // One clock cycle: drive at the falling edge, update the model, check at the next falling edge
  task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic f,
                      input string tag, output bit accepted);
    bit mrdy;
    bit mval;
    bit in_x;
    bit out_x;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    mrdy  = ready_en && (model_q.size() < 2);
    mval  = (model_q.size() > 0);
    in_x  = v && mrdy;
    out_x = mval && r;
    if (out_x) exp_xfer++;
    if (mval && !r) exp_stall++;
    if (f) begin
      model_q.delete();
    end else begin
      if (out_x) void'(model_q.pop_front());
      if (in_x) model_q.push_back(d);
    end
    accepted = in_x && !f;
    @(posedge clk);
    ready_en = 1'b1;
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    bit           acc;
    logic [W-1:0] src[$];
    int           guard;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = {W{1'b0}};
    ready_en = 1'b0; exp_xfer = 0; exp_stall = 0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Release: in_ready rises on the first edge
    step(1'b0, {W{1'b0}}, 1'b1, 1'b0, "release", acc);

    // Single vector, one-cycle latency
    step(1'b1, 1024'hA5, 1'b1, 1'b0, "a5_in", acc);
    check_value("a5.out_data", out_data, 1024'hA5);
    step(1'b0, {W{1'b0}}, 1'b1, 1'b0, "a5_drain", acc);

    // 100 back-to-back vectors
    for (int i = 0; i < 100; i++) step(1'b1, W'(i), 1'b1, 1'b0, "b2b", acc);
    step(1'b0, {W{1'b0}}, 1'b1, 1'b0, "b2b_drain", acc);

    // Backpressure: 1,2 accepted, 3 held off, then drained in order
    src.delete();
    src.push_back(W'(1)); src.push_back(W'(2)); src.push_back(W'(3));
    for (int i = 0; i < 4; i++) begin
      step(src.size() > 0, (src.size() > 0) ? src[0] : {W{1'b0}}, 1'b0, 1'b0, "stall", acc);
      if (acc) void'(src.pop_front());
    end
    check_value("stall.pending", W'(src.size()), W'(1));
    guard = 0;
    while ((src.size() > 0 || model_q.size() > 0) && guard < 10) begin
      step(src.size() > 0, (src.size() > 0) ? src[0] : {W{1'b0}}, 1'b1, 1'b0, "unstall", acc);
      if (acc) void'(src.pop_front());
      guard++;
    end
    check_value("unstall.guard", W'(guard < 10), W'(1'b1));

    // Flush while FULL with a same-cycle input
    step(1'b1, W'(11), 1'b0, 1'b0, "fill", acc);
    step(1'b1, W'(22), 1'b0, 1'b0, "fill", acc);
    step(1'b1, W'(33), 1'b0, 1'b1, "flush", acc);
    for (int i = 0; i < 3; i++) step(1'b0, {W{1'b0}}, 1'b1, 1'b0, "post_flush", acc);

    // Asynchronous reset mid-cycle while FULL
    step(1'b1, W'(44), 1'b0, 1'b0, "fill2", acc);
    step(1'b1, W'(55), 1'b0, 1'b0, "fill2", acc);
    #2 rst = 1'b1;
    #1 check_reset_state("async_rst");
    model_q.delete(); exp_xfer = 0; exp_stall = 0; ready_en = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, {W{1'b0}}, 1'b0, 1'b0, "rst_release", acc);

    // Random traffic at 50% valid / 50% ready
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(1, 0) == 1, rand_vec(), $urandom_range(1, 0) == 1, 1'b0, "rand", acc);
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
